irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised external-interrupt controller for the RISC-V core.
- Successor to the fixed-width interrupt-flag input: NUM_SRC sources, per-source priority, edge/level mode, threshold, and a claim/complete handshake.
- Sits on the RIB bus as a slave; irq_o/irq_id_o feed the core's interrupt-flag input.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31); source i has ID i+1, ID 0 = none
PRIO_W, 3, priority width; priority 0 = never interrupts
ADDR_W, 32, bus address width; only addr_i[7:0] decoded
DATA_W, 32, bus data width
(localparam ID_W = clog2(NUM_SRC+1))

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
src_i  in  NUM_SRC  raw interrupt sources
req_i  in  1  bus access request, single-cycle
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_W  byte address
wdata_i  in  DATA_W  write data
rdata_o  out  DATA_W  read data, valid cycle after req_i
irq_o  out  1  interrupt request to core
irq_id_o  out  ID_W  ID of current best candidate, 0 if none

Behaviour:
- Reset: all pending, in_service, ENABLE, EDGE, PRIO and THRESHOLD registers = 0; rdata_o = 0; irq_o = 0; irq_id_o = 0; edge-history flops = 0.
- Register map (word aligned):
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW.
  - 0x08 EDGE: RW; 1 = rising-edge mode, 0 = level mode.
  - 0x0C THRESHOLD: RW, PRIO_W bits.
  - 0x10 CLAIM/COMPLETE.
  - 0x20 + 4*i PRIO[i]: RW.
  - Unmapped addresses: read 0, writes ignored. Bits above NUM_SRC/PRIO_W read 0.
- Pending set:
  - Level source: pending follows src_i while not in_service.
  - Edge source: src_i rising edge (src_i & ~src_q) sets pending, which holds until claimed. One-deep: an edge during in_service re-pends once.
- Per-source state machine: IDLE -> PEND (set condition) -> SERV (claimed) -> IDLE (complete). From SERV, an edge moves the source to SERV+PEND, which becomes PEND on complete.
- Arbitration (combinational):
  - Candidates: pending & enable & ~in_service & (prio > threshold).
  - Highest priority wins; ties go to the lowest ID.
  - Result is registered into irq_id_o, and irq_o = (irq_id_o != 0). Latency: source change to irq_o = 2 cycles for edge mode (src_q stage + output register), 1 cycle for level mode.
- Claim (read of 0x10):
  - Returns the registered irq_id_o in rdata_o next cycle.
  - In the same cycle, clears pending and sets in_service for that ID.
  - Claim with ID 0 has no side effect.
- Complete (write of 0x10):
  - wdata_i[ID_W-1:0] = ID; clears in_service if set.
  - ID not in service, or ID 0: ignored.
  - A still-asserted level source re-pends on the following cycle.
- Simultaneous events:
  - Edge arrives in the same cycle as a claim of that source: pending stays set, in_service is also set.
  - Complete and a new edge in the same cycle on the same source: both take effect.
  - ENABLE/PRIO write in the same cycle as a claim: the claim uses the pre-write registered ID.
- Priority/enable change to a non-candidate while irq_o=1: irq_o drops on the next registered update; no claim is required.
- Reset mid-service: all state is lost; the source returns to IDLE and a still-high level source re-pends after reset deasserts.

Optional Feature:
IRQ_CTRL_SYNC_EN:
- Defined: src_i passes through a two-flop synchroniser before edge/level logic; latency +2 cycles; synchroniser flops reset to 0.
- Undefined: src_i is used directly; sources must be synchronous to clk.

Decomposition:
- Shared package/defines: register offsets (IRQ_PENDING_OFS, IRQ_ENABLE_OFS, IRQ_EDGE_OFS, IRQ_THRESH_OFS, IRQ_CLAIM_OFS, IRQ_PRIO_BASE), ID_NONE = 0, source-state encoding (IDLE/PEND/SERV).
- Sub-module irq_ctrl_arb: purely combinational priority tree (candidate vector + priorities -> best ID), reusable and separately verifiable.

Test Plan:
- Reset: assert rst 2 cycles with src_i=all 1 -> irq_o=0, irq_id_o=0, all registers read 0.
- Basic level: PRIO[2]=3, ENABLE=0x04, THRESHOLD=0, src_i[2]=1 -> irq_o=1, irq_id_o=3 after 1 cycle; CLAIM read returns 3, irq_o=0; complete 3 with src still high -> irq_o=1 again after 1 cycle.
- Arbitration: sources 1 and 5 pending, PRIO[1]=2, PRIO[5]=6 -> ID 6; set PRIO[1]=6 -> ID 2 (tie, lowest ID); THRESHOLD=6 -> irq_o=0.
- Edge re-pend: EDGE[0]=1, pulse src_i[0], claim (returns 1), pulse again while in service -> irq_o stays 0; complete 1 -> irq_o=1, id 1.
- Corner: claim with no candidate returns 0; complete of ID 4 not in service is ignored; edge on the claim cycle leaves PENDING bit set.
- Reset mid-service: claim ID 3, assert rst -> in_service cleared; src still high -> irq_o=1 one cycle after release, after ENABLE/PRIO are reprogrammed.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map, source-state encoding and next-state helper for irq_ctrl
package irq_ctrl_pkg;

   localparam logic [7:0] IRQ_PENDING_OFS = 8'h00;
   localparam logic [7:0] IRQ_ENABLE_OFS  = 8'h04;
   localparam logic [7:0] IRQ_EDGE_OFS    = 8'h08;
   localparam logic [7:0] IRQ_THRESH_OFS  = 8'h0C;
   localparam logic [7:0] IRQ_CLAIM_OFS   = 8'h10;
   localparam logic [7:0] IRQ_PRIO_BASE   = 8'h20;

   localparam int ID_NONE = 0;

   // Bit 0 = stored pending (edge sources only), bit 1 = in service
   localparam logic [1:0] ST_IDLE      = 2'b00;
   localparam logic [1:0] ST_PEND      = 2'b01;
   localparam logic [1:0] ST_SERV      = 2'b10;
   localparam logic [1:0] ST_SERV_PEND = 2'b11;

   function automatic logic [1:0] src_next(input logic [1:0] st,
                                           input logic       edge_mode,
                                           input logic       rise,
                                           input logic       claim,
                                           input logic       complete);
      logic pend;
      logic serv;
      // A rising edge wins over a same-cycle claim so the edge is not lost
      pend = edge_mode & ((st[0] & ~claim) | rise);
      serv = claim | (st[1] & ~complete);
      if (serv && pend)
         return ST_SERV_PEND;
      else if (serv)
         return ST_SERV;
      else if (pend)
         return ST_PEND;
      else
         return ST_IDLE;
   endfunction

endpackage

// File: rtl/irq_ctrl_arb.sv
// rtl/irq_ctrl_arb.sv - combinational arbiter: highest priority wins, ties to the lowest ID
module irq_ctrl_arb #(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3,
   parameter int ID_W    = 4
) (
   input  logic [NUM_SRC-1:0]             cand,
   input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
   output logic [ID_W-1:0]                best_id
);

   logic [PRIO_W-1:0] best_prio;

   // Ascending scan with strict '>' keeps the lowest ID on equal priority
   always_comb begin
      best_id   = '0;
      best_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cand[i] && ((best_id == '0) || (prio[i] > best_prio))) begin
            best_id   = ID_W'(i + 1);
            best_prio = prio[i];
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - external interrupt controller; IRQ_CTRL_SYNC_EN adds a 2-flop source synchroniser
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SRC-1:0]           src_i,
   input  logic                         req_i,
   input  logic                         we_i,
   input  logic [ADDR_W-1:0]            addr_i,
   input  logic [DATA_W-1:0]            wdata_i,
   output logic [DATA_W-1:0]            rdata_o,
   output logic                         irq_o,
   output logic [$clog2(NUM_SRC+1)-1:0] irq_id_o
);

   localparam int ID_W = $clog2(NUM_SRC + 1);

   logic [NUM_SRC-1:0]             src_s;
   logic [NUM_SRC-1:0]             src_q;
   logic [NUM_SRC-1:0]             enable_q;
   logic [NUM_SRC-1:0]             edge_q;
   logic [PRIO_W-1:0]              thresh_q;
   logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
   logic [NUM_SRC-1:0][1:0]        st_q;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] sync_q1;
   logic [NUM_SRC-1:0] sync_q2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= src_i;
         sync_q2 <= sync_q1;
      end
   end

   assign src_s = sync_q2;
`else
   assign src_s = src_i;
`endif

   logic [7:0]      ofs;
   logic [7:0]      prio_rel;
   logic            prio_hit;
   logic            rd;
   logic            wr;
   logic            claim_en;
   logic            complete_en;
   logic [ID_W-1:0] cmp_id;
   logic            unused_bits;

   assign ofs         = addr_i[7:0];
   assign rd          = req_i & ~we_i;
   assign wr          = req_i & we_i;
   assign prio_rel    = ofs - IRQ_PRIO_BASE;
   assign prio_hit    = (ofs >= IRQ_PRIO_BASE) && (ofs[1:0] == 2'b00) &&
                        (prio_rel[7:2] < 6'(NUM_SRC));
   assign claim_en    = rd && (ofs == IRQ_CLAIM_OFS) && (irq_id_o != ID_W'(ID_NONE));
   assign complete_en = wr && (ofs == IRQ_CLAIM_OFS);
   assign cmp_id      = wdata_i[ID_W-1:0];
   assign unused_bits = ^{addr_i, wdata_i};

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] serv;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] claim_v;
   logic [NUM_SRC-1:0] comp_v;
   logic [NUM_SRC-1:0] cand;

   // Level pending is combinational so a level source reaches irq_o in one cycle;
   // the claimed ID is masked so irq_o drops right after the claim
   always_comb begin
      rise    = '0;
      serv    = '0;
      pend    = '0;
      claim_v = '0;
      comp_v  = '0;
      cand    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rise[i]    = src_s[i] & ~src_q[i];
         serv[i]    = |(st_q[i] & ST_SERV);
         pend[i]    = edge_q[i] ? |(st_q[i] & ST_PEND) : (src_s[i] & ~serv[i]);
         claim_v[i] = claim_en && (irq_id_o == ID_W'(i + 1));
         comp_v[i]  = complete_en && (cmp_id == ID_W'(i + 1)) && serv[i];
         cand[i]    = pend[i] & enable_q[i] & ~serv[i] & ~claim_v[i] &
                      (prio_q[i] > thresh_q);
      end
   end

   logic [ID_W-1:0] best_id;

   irq_ctrl_arb #(
      .NUM_SRC (NUM_SRC),
      .PRIO_W  (PRIO_W),
      .ID_W    (ID_W)
   ) u_arb (
      .cand    (cand),
      .prio    (prio_q),
      .best_id (best_id)
   );

   logic [DATA_W-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (ofs)
         IRQ_PENDING_OFS: rd_mux[NUM_SRC-1:0] = pend;
         IRQ_ENABLE_OFS:  rd_mux[NUM_SRC-1:0] = enable_q;
         IRQ_EDGE_OFS:    rd_mux[NUM_SRC-1:0] = edge_q;
         IRQ_THRESH_OFS:  rd_mux[PRIO_W-1:0]  = thresh_q;
         IRQ_CLAIM_OFS:   rd_mux[ID_W-1:0]    = irq_id_o;
         default: begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (prio_hit && (prio_rel[7:2] == 6'(i)))
                  rd_mux[PRIO_W-1:0] = prio_q[i];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q    <= '0;
         enable_q <= '0;
         edge_q   <= '0;
         thresh_q <= '0;
         prio_q   <= '0;
         for (int i = 0; i < NUM_SRC; i++)
            st_q[i] <= ST_IDLE;
         irq_id_o <= '0;
         rdata_o  <= '0;
      end else begin
         src_q <= src_s;
         for (int i = 0; i < NUM_SRC; i++)
            st_q[i] <= src_next(st_q[i], edge_q[i], rise[i], claim_v[i], comp_v[i]);
         if (wr) begin
            case (ofs)
               IRQ_ENABLE_OFS: enable_q <= wdata_i[NUM_SRC-1:0];
               IRQ_EDGE_OFS:   edge_q   <= wdata_i[NUM_SRC-1:0];
               IRQ_THRESH_OFS: thresh_q <= wdata_i[PRIO_W-1:0];
               default: ;
            endcase
            for (int i = 0; i < NUM_SRC; i++) begin
               if (prio_hit && (prio_rel[7:2] == 6'(i)))
                  prio_q[i] <= wdata_i[PRIO_W-1:0];
            end
         end
         irq_id_o <= best_id;
         rdata_o  <= rd ? rd_mux : '0;
      end
   end

   assign irq_o = (irq_id_o != ID_W'(ID_NONE));

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl (vector table, directed corners, random vs model)
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src = '0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;
   logic [3:0]  irq_id;

   always #5 clk = ~clk;

   irq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .src_i    (src),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .rdata_o  (rdata),
      .irq_o    (irq),
      .irq_id_o (irq_id)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit        we;
      bit [7:0]  addr;
      bit [31:0] wdata;
      bit [31:0] exp;
   } tv_t;

   tv_t tv[22];

   bit [7:0] m_en, m_edge, m_pend, m_serv, m_srcq;
   int       m_thr, m_id;
   int       m_prio[8];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1;
      addr = ($urandom() & 32'hFFFF_FF00) | {24'h0, a};
      wdata = d;
      tick;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      req = 1'b1; we = 1'b0;
      addr = ($urandom() & 32'hFFFF_FF00) | {24'h0, a};
      tick;
      d = rdata;
      req = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; req = 1'b0; we = 1'b0;
      repeat (n) tick;
      rst = 1'b0;
   endtask

   // Reference: scan priorities from the top down, IDs from the bottom up
   function automatic int model_best(input bit [7:0] pv, input int claim_id);
      for (int p = 7; p > m_thr; p--)
         for (int i = 0; i < 8; i++)
            if (pv[i] && m_en[i] && !m_serv[i] && (i + 1 != claim_id) && m_prio[i] == p)
               return i + 1;
      return 0;
   endfunction

   function automatic bit [31:0] model_read(input bit [7:0] a, input bit [7:0] pv);
      case (a)
         8'h00: return {24'h0, pv};
         8'h04: return {24'h0, m_en};
         8'h08: return {24'h0, m_edge};
         8'h0C: return 32'(m_thr);
         8'h10: return 32'(m_id);
         default: begin
            if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00)
               return 32'(m_prio[int'((a - 8'h20) >> 2)]);
            return 32'h0;
         end
      endcase
   endfunction

   task automatic model_step(input bit [7:0] s, input bit r, input bit w, input bit [7:0] a,
                             input bit [31:0] d, output bit [31:0] exp_rd);
      bit [7:0] pv;
      int       claim_id, comp_id, nxt;
      for (int i = 0; i < 8; i++)
         pv[i] = m_edge[i] ? m_pend[i] : (s[i] && !m_serv[i]);
      claim_id = (r && !w && a == 8'h10) ? m_id : 0;
      comp_id  = (r && w && a == 8'h10) ? int'(d[3:0]) : 0;
      nxt      = model_best(pv, claim_id);
      exp_rd   = (r && !w) ? model_read(a, pv) : 32'h0;
      for (int i = 0; i < 8; i++) begin
         if (claim_id == i + 1) begin
            m_serv[i] = 1'b1;
            m_pend[i] = 1'b0;
         end else if (comp_id == i + 1) begin
            m_serv[i] = 1'b0;
         end
         if (m_edge[i] && s[i] && !m_srcq[i]) m_pend[i] = 1'b1;
         if (!m_edge[i]) m_pend[i] = 1'b0;
         m_srcq[i] = s[i];
      end
      if (r && w) begin
         case (a)
            8'h04: m_en   = d[7:0];
            8'h08: m_edge = d[7:0];
            8'h0C: m_thr  = int'(d[2:0]);
            default:
               if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00)
                  m_prio[int'((a - 8'h20) >> 2)] = int'(d[2:0]);
         endcase
      end
      m_id = nxt;
   endtask

   logic [31:0] d;
   bit   [31:0] exp_rd;
   bit          r_r, r_w;
   bit   [7:0]  r_a;
   bit   [31:0] r_d;
   int          op;

   initial begin
      tv[0]  = '{1'b0, 8'h00, 32'h0,        32'h0};
      tv[1]  = '{1'b0, 8'h04, 32'h0,        32'h0};
      tv[2]  = '{1'b0, 8'h08, 32'h0,        32'h0};
      tv[3]  = '{1'b0, 8'h0C, 32'h0,        32'h0};
      tv[4]  = '{1'b0, 8'h10, 32'h0,        32'h0};
      tv[5]  = '{1'b0, 8'h20, 32'h0,        32'h0};
      tv[6]  = '{1'b0, 8'h3C, 32'h0,        32'h0};
      tv[7]  = '{1'b1, 8'h04, 32'hFFFFFFFF, 32'h0};
      tv[8]  = '{1'b0, 8'h04, 32'h0,        32'hFF};
      tv[9]  = '{1'b1, 8'h08, 32'h0000A5A5, 32'h0};
      tv[10] = '{1'b0, 8'h08, 32'h0,        32'hA5};
      tv[11] = '{1'b1, 8'h0C, 32'hFFFFFFFF, 32'h0};
      tv[12] = '{1'b0, 8'h0C, 32'h0,        32'h7};
      tv[13] = '{1'b1, 8'h3C, 32'h0000FFFE, 32'h0};
      tv[14] = '{1'b0, 8'h3C, 32'h0,        32'h6};
      tv[15] = '{1'b1, 8'h20, 32'h5,        32'h0};
      tv[16] = '{1'b0, 8'h20, 32'h0,        32'h5};
      tv[17] = '{1'b1, 8'h40, 32'h7,        32'h0};
      tv[18] = '{1'b0, 8'h40, 32'h0,        32'h0};
      tv[19] = '{1'b1, 8'h00, 32'hFF,       32'h0};
      tv[20] = '{1'b0, 8'h00, 32'h0,        32'h0};
      tv[21] = '{1'b0, 8'h22, 32'h0,        32'h0};

      // Reset with all sources high
      src = 8'hFF;
      do_reset(2);
      rst = 1'b1;
      tick;
      check("reset irq_o", 32'(irq), 32'h0);
      check("reset irq_id", 32'(irq_id), 32'h0);
      check("reset rdata", rdata, 32'h0);
      rst = 1'b0; src = 8'h00;
      tick;
      check("post-reset irq_o", 32'(irq), 32'h0);

      for (int k = 0; k < 22; k++) begin
         if (tv[k].we) wr(tv[k].addr, tv[k].wdata);
         else begin
            rd(tv[k].addr, d);
            check($sformatf("vec%0d rd 0x%02h", k, tv[k].addr), d, tv[k].exp);
         end
      end

      // Basic level flow
      do_reset(1);
      wr(8'h28, 32'h3); wr(8'h04, 32'h04); wr(8'h0C, 32'h0);
      src = 8'h04;
      tick;
      check("level irq_id", 32'(irq_id), 32'h3);
      check("level irq_o", 32'(irq), 32'h1);
      rd(8'h10, d);
      check("level claim id", d, 32'h3);
      check("level irq after claim", 32'(irq), 32'h0);
      tick;
      check("level in service", 32'(irq), 32'h0);
      wr(8'h10, 32'h3);
      check("level complete cycle", 32'(irq), 32'h0);
      tick;
      check("level re-pend", 32'(irq_id), 32'h3);

      // Arbitration
      do_reset(1);
      src = 8'h00;
      wr(8'h24, 32'h2); wr(8'h34, 32'h6); wr(8'h04, 32'h22);
      src = 8'h22;
      tick;
      check("arb high prio", 32'(irq_id), 32'h6);
      wr(8'h24, 32'h6);
      tick;
      check("arb tie lowest id", 32'(irq_id), 32'h2);
      wr(8'h0C, 32'h6);
      tick;
      check("arb threshold", 32'(irq), 32'h0);

      // Edge re-pend while in service
      src = 8'h00;
      do_reset(1);
      wr(8'h08, 32'h1); wr(8'h04, 32'h1); wr(8'h20, 32'h1);
      src = 8'h01;
      tick;
      check("edge latency 1", 32'(irq_id), 32'h0);
      tick;
      check("edge latency 2", 32'(irq_id), 32'h1);
      src = 8'h00;
      rd(8'h10, d);
      check("edge claim id", d, 32'h1);
      src = 8'h01; tick; src = 8'h00; tick; tick;
      check("edge in service", 32'(irq), 32'h0);
      rd(8'h00, d);
      check("edge pending held", d, 32'h1);
      wr(8'h10, 32'h1);
      tick;
      check("edge re-pend id", 32'(irq_id), 32'h1);

      // Corners
      rd(8'h10, d);
      check("corner claim 1", d, 32'h1);
      rd(8'h10, d);
      check("corner claim none", d, 32'h0);
      wr(8'h10, 32'h1);
      src = 8'h01; tick; src = 8'h00; tick;
      check("corner pend again", 32'(irq_id), 32'h1);
      src = 8'h01;
      rd(8'h10, d);
      check("corner edge-on-claim id", d, 32'h1);
      src = 8'h00;
      rd(8'h00, d);
      check("corner edge-on-claim pending", d, 32'h1);
      check("corner edge-on-claim irq", 32'(irq), 32'h0);
      wr(8'h10, 32'h4);
      tick;
      check("corner complete 4 ignored", 32'(irq), 32'h0);
      wr(8'h10, 32'h1);
      tick;
      check("corner complete 1", 32'(irq_id), 32'h1);

      // Reset mid-service
      src = 8'h00;
      do_reset(1);
      wr(8'h28, 32'h3); wr(8'h04, 32'h04);
      src = 8'h04;
      tick;
      rd(8'h10, d);
      check("midrst claim", d, 32'h3);
      do_reset(1);
      rd(8'h00, d);
      check("midrst pending", d, 32'h04);
      check("midrst irq off", 32'(irq), 32'h0);
      wr(8'h28, 32'h3); wr(8'h04, 32'h04);
      tick;
      check("midrst re-pend", 32'(irq_id), 32'h3);

      // Random traffic against the reference model
      src = 8'h00;
      do_reset(2);
      m_en = '0; m_edge = '0; m_pend = '0; m_serv = '0; m_srcq = '0;
      m_thr = 0; m_id = 0;
      for (int i = 0; i < 8; i++) m_prio[i] = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) src = src ^ 8'(1 << $urandom_range(0, 7));
         op = $urandom_range(0, 9);
         r_r = 1'b1; r_w = 1'b1; r_a = 8'h00; r_d = $urandom();
         case (op)
            0, 1, 2: r_r = 1'b0;
            3: r_a = 8'h04;
            4: r_a = 8'h08;
            5: begin r_a = 8'h0C; r_d = (r_d & ~32'h7) | $urandom_range(0, 3); end
            6: r_a = 8'h20 + 8'(4 * $urandom_range(0, 8));
            7: begin r_a = 8'h10; r_d = (r_d & ~32'hF) | $urandom_range(0, 9); end
            8: begin r_a = 8'h10; r_w = 1'b0; end
            default: begin r_a = 8'(4 * $urandom_range(0, 17)); r_w = 1'b0; end
         endcase
         req = r_r; we = r_w;
         addr = ($urandom() & 32'hFFFF_FF00) | {24'h0, r_a};
         wdata = r_d;
         model_step(src, r_r, r_w, r_a, r_d, exp_rd);
         tick;
         check($sformatf("rnd%0d irq_id", c), 32'(irq_id), 32'(m_id));
         check($sformatf("rnd%0d irq_o", c), 32'(irq), 32'(m_id != 0));
         if (r_r && !r_w)
            check($sformatf("rnd%0d rdata 0x%02h", c, r_a), rdata, exp_rd);
      end
      req = 1'b0; we = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
